// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: the RegBus width, the data-memory
// access FSM state type and the default timeout limit.
// Optional macro DM_TIMEOUT_EN adds the ERR state.
package pipe_ctrl_pkg;

  // RegBus: width of address and data buses between the pipeline and memory.
  localparam int unsigned RegBusWidth = 32;
  typedef logic [RegBusWidth-1:0] reg_bus_t;

  // Default number of ACCESS cycles without dm_ack before an abort.
  localparam int unsigned DM_TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
`ifdef DM_TIMEOUT_EN
    ,
    ERR    = 2'd3
`endif
  } dm_state_t;

endpackage

// File: rtl/dm_timeout_cnt.sv
// Counts ACCESS cycles without acknowledge. hit is asserted in the cycle that
// would bring the count to LIMIT, so the FSM can branch on the same edge.
module dm_timeout_cnt #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Cycle counter: cleared when a new access starts, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller: registers a single request per
// memory instruction, stalls the pipeline until the acknowledge arrives and
// captures load data for the MEM/WB mux.
// Optional macro DM_TIMEOUT_EN enables the ACCESS timeout and the ERR state.
module dm_access_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DM_TIMEOUT_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_DM_read,
  input  logic                   mem_DM_write,
  input  logic [RegBusWidth-1:0] mem_alu_result,
  input  logic [RegBusWidth-1:0] mem_sw_o,
  input  logic                   dm_ack,
  input  logic [RegBusWidth-1:0] dm_rdata,
  output logic                   dm_req,
  output logic                   dm_we,
  output logic [RegBusWidth-1:0] dm_addr,
  output logic [RegBusWidth-1:0] dm_wdata,
  output logic [RegBusWidth-1:0] mem_lw_data,
  output logic                   pipe_stall,
  output logic                   dm_err
);

  dm_state_t state, state_nxt;
  logic      access;
  logic      tmo_hit;

  assign access = mem_DM_read | mem_DM_write;

`ifdef DM_TIMEOUT_EN
  logic err_q;

  dm_timeout_cnt #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk(clk),
    .rst(rst),
    .clr((state == IDLE) && access),
    .en ((state == ACCESS) && !dm_ack),
    .hit(tmo_hit)
  );

  assign dm_err = err_q;
`else
  logic unused_timeout_cfg;

  assign tmo_hit            = 1'b0;
  assign dm_err             = 1'b0;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and combinational stall.
  always_comb begin
    state_nxt  = state;
    pipe_stall = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          state_nxt  = ACCESS;
          pipe_stall = 1'b1;
        end
      end
      ACCESS: begin
        pipe_stall = 1'b1;
        // A late acknowledge on the limit cycle still completes normally.
        if (dm_ack) begin
          state_nxt = DONE;
        end else if (tmo_hit) begin
`ifdef DM_TIMEOUT_EN
          state_nxt = ERR;
`endif
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
`ifdef DM_TIMEOUT_EN
      ERR: begin
        pipe_stall = 1'b1;
        state_nxt  = DONE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (rst) begin
      pipe_stall = 1'b0;
    end
  end

  // Registered memory request and load-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      mem_lw_data <= '0;
`ifdef DM_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            dm_req   <= 1'b1;
            dm_we    <= mem_DM_write;
            dm_addr  <= mem_alu_result;
            dm_wdata <= mem_sw_o;
          end
        end
        ACCESS: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
            if (!dm_we) begin
              mem_lw_data <= dm_rdata;
            end
          end else if (tmo_hit) begin
            dm_req      <= 1'b0;
            mem_lw_data <= '0;
`ifdef DM_TIMEOUT_EN
            err_q       <= 1'b1;
`endif
          end
        end
`ifdef DM_TIMEOUT_EN
        ERR: begin
          err_q <= 1'b0;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl. Build with DM_TIMEOUT_EN defined to
// exercise the timeout path with TIMEOUT_CYC=4.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_DM_read;
  logic        mem_DM_write;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_sw_o;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] mem_lw_data;
  logic        pipe_stall;
  logic        dm_err;

  int checks   = 0;
  int failures = 0;

  dm_access_ctrl #(
    .TIMEOUT_CYC(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_DM_read   (mem_DM_read),
    .mem_DM_write  (mem_DM_write),
    .mem_alu_result(mem_alu_result),
    .mem_sw_o      (mem_sw_o),
    .dm_ack        (dm_ack),
    .dm_rdata      (dm_rdata),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .mem_lw_data   (mem_lw_data),
    .pipe_stall    (pipe_stall),
    .dm_err        (dm_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then let registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    chk({tag, "_req"},   {31'd0, dm_req}, {31'd0, req});
    chk({tag, "_we"},    {31'd0, dm_we},  {31'd0, we});
    chk({tag, "_addr"},  dm_addr,  addr);
    chk({tag, "_wdata"}, dm_wdata, wdata);
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk(tag, {31'd0, pipe_stall}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1; mem_DM_read = 1'b1; mem_DM_write = 1'b0;
    mem_alu_result = 32'h0; mem_sw_o = 32'h0; dm_ack = 1'b0; dm_rdata = 32'h0;

    // Reset: stall held low even with a pending access request.
    tick(); tick();
    chk_stall("rst_stall", 1'b0);
    mem_DM_read = 1'b0;
    rst = 1'b0;
    settle();
    chk_bus("rst", 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst_lw", mem_lw_data, 32'h0);
    chk("rst_err", {31'd0, dm_err}, 32'h0);
    chk_stall("rst_idle_stall", 1'b0);

    // Load 0x40, ack in first ACCESS cycle.
    mem_DM_read = 1'b1; mem_alu_result = 32'h0000_0040; mem_sw_o = 32'h1111_2222;
    settle();
    chk_stall("ld_idle_stall", 1'b1);
    tick();
    chk_bus("ld_acc", 1'b1, 1'b0, 32'h0000_0040, 32'h1111_2222);
    chk_stall("ld_acc_stall", 1'b1);
    dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    tick();
    dm_ack = 1'b0; dm_rdata = 32'h0;
    settle();
    chk("ld_done_req", {31'd0, dm_req}, 32'h0);
    chk("ld_done_lw", mem_lw_data, 32'hDEAD_BEEF);
    chk_stall("ld_done_stall", 1'b0);

    // Back-to-back store enters MEM at the end of DONE; 3 wait cycles.
    tick();
    mem_DM_read = 1'b0; mem_DM_write = 1'b1;
    mem_alu_result = 32'h0000_0080; mem_sw_o = 32'h1234_5678;
    settle();
    chk("st_idle_req", {31'd0, dm_req}, 32'h0);
    chk_stall("st_idle_stall", 1'b1);
    tick();
    // Changing the inputs must not disturb the registered request.
    mem_alu_result = 32'hFFFF_0000; mem_sw_o = 32'h0BAD_0BAD;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_bus($sformatf("st_acc%0d", i), 1'b1, 1'b1, 32'h0000_0080, 32'h1234_5678);
      chk_stall($sformatf("st_acc%0d_stall", i), 1'b1);
      if (i == 3) begin
        dm_ack = 1'b1; dm_rdata = 32'hBAD0_BAD0;
      end
      tick();
    end
    dm_ack = 1'b0;
    settle();
    chk("st_done_req", {31'd0, dm_req}, 32'h0);
    chk("st_done_lw", mem_lw_data, 32'hDEAD_BEEF);
    chk_stall("st_done_stall", 1'b0);
    mem_DM_write = 1'b0;
    tick();

    // Spurious acknowledge in IDLE.
    dm_ack = 1'b1; dm_rdata = 32'h5555_5555;
    tick(); tick();
    chk("spur_idle_req", {31'd0, dm_req}, 32'h0);
    chk("spur_idle_lw", mem_lw_data, 32'hDEAD_BEEF);
    chk_stall("spur_idle_stall", 1'b0);
    dm_ack = 1'b0;

    // Read and write together perform a store; ack in DONE is ignored.
    mem_DM_read = 1'b1; mem_DM_write = 1'b1;
    mem_alu_result = 32'h0000_0100; mem_sw_o = 32'hA5A5_A5A5;
    tick();
    chk_bus("rw_acc", 1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5);
    dm_ack = 1'b1; dm_rdata = 32'h0000_0077;
    tick();
    chk("rw_done_lw", mem_lw_data, 32'hDEAD_BEEF);
    mem_DM_read = 1'b0; mem_DM_write = 1'b0;
    dm_rdata = 32'h0000_0066;
    tick();
    dm_ack = 1'b0;
    settle();
    chk("ackdone_req", {31'd0, dm_req}, 32'h0);
    chk("ackdone_lw", mem_lw_data, 32'hDEAD_BEEF);
    chk_stall("ackdone_stall", 1'b0);

    // Reset during ACCESS, then a late acknowledge.
    mem_DM_read = 1'b1; mem_alu_result = 32'h0000_0200; mem_sw_o = 32'h0;
    tick();
    chk("rsta_req", {31'd0, dm_req}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_DM_read = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h9999_9999;
    settle();
    chk_bus("rsta", 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rsta_lw", mem_lw_data, 32'h0);
    tick();
    dm_ack = 1'b0;
    settle();
    chk("late_req", {31'd0, dm_req}, 32'h0);
    chk("late_lw", mem_lw_data, 32'h0);
    chk_stall("late_stall", 1'b0);
    chk("late_err", {31'd0, dm_err}, 32'h0);

    // Load with ack in second ACCESS cycle to give mem_lw_data a known value.
    mem_DM_read = 1'b1; mem_alu_result = 32'h0000_0044;
    tick(); tick();
    dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
    tick();
    dm_ack = 1'b0;
    settle();
    chk("ld2_lw", mem_lw_data, 32'hCAFE_F00D);
    mem_DM_read = 1'b0;
    tick();

`ifdef DM_TIMEOUT_EN
    // No acknowledge: ERR after 4 ACCESS cycles.
    mem_DM_read = 1'b1; mem_alu_result = 32'h0000_0300;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tmo_acc%0d_err", i), {31'd0, dm_err}, 32'h0);
      chk($sformatf("tmo_acc%0d_req", i), {31'd0, dm_req}, 32'h1);
      chk_stall($sformatf("tmo_acc%0d_stall", i), 1'b1);
      tick();
    end
    chk("tmo_err", {31'd0, dm_err}, 32'h1);
    chk("tmo_err_req", {31'd0, dm_req}, 32'h0);
    chk("tmo_err_lw", mem_lw_data, 32'h0);
    chk_stall("tmo_err_stall", 1'b1);
    tick();
    chk("tmo_done_err", {31'd0, dm_err}, 32'h0);
    chk_stall("tmo_done_stall", 1'b0);
    mem_DM_read = 1'b0;
    tick();

    // Acknowledge on the limit cycle completes normally.
    mem_DM_read = 1'b1; mem_alu_result = 32'h0000_0304;
    tick(); tick(); tick(); tick();
    dm_ack = 1'b1; dm_rdata = 32'h0123_4567;
    tick();
    dm_ack = 1'b0;
    settle();
    chk("lim_err", {31'd0, dm_err}, 32'h0);
    chk("lim_lw", mem_lw_data, 32'h0123_4567);
    chk_stall("lim_stall", 1'b0);
    mem_DM_read = 1'b0;
    tick();
`else
    // Without the timeout the access waits indefinitely.
    mem_DM_read = 1'b1; mem_alu_result = 32'h0000_0300;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    chk("wait_req", {31'd0, dm_req}, 32'h1);
    chk("wait_err", {31'd0, dm_err}, 32'h0);
    chk_stall("wait_stall", 1'b1);
    chk("wait_lw", mem_lw_data, 32'hCAFE_F00D);
    dm_ack = 1'b1; dm_rdata = 32'h0123_4567;
    tick();
    dm_ack = 1'b0;
    settle();
    chk("wait_done_lw", mem_lw_data, 32'h0123_4567);
    chk_stall("wait_done_stall", 1'b0);
    mem_DM_read = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYC, default 16, giving the number of ACCESS cycles without dm_ack before an abort (used only with DM_TIMEOUT_EN).
REQ-002 SHALL provide the ports in the order below.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_DM_read  in  1  MEM-stage load request from the EXE/MEM register.
- mem_DM_write  in  1  MEM-stage store request from the EXE/MEM register.
- mem_alu_result  in  32  MEM-stage effective address.
- mem_sw_o  in  32  MEM-stage store data.
- dm_ack  in  1  data memory completion, one cycle.
- dm_rdata  in  32  data memory read data, valid with dm_ack.
- dm_req  out  1  registered request to data memory.
- dm_we  out  1  registered write enable, 1 = store.
- dm_addr  out  32  registered address.
- dm_wdata  out  32  registered store data.
- mem_lw_data  out  32  captured load data for the MEM/WB mux.
- pipe_stall  out  1  freeze PC, IF/ID, ID/EXE and EXE/MEM registers.
- dm_err  out  1  one-cycle timeout pulse.

Function
REQ-003 SHALL implement the FSM states IDLE, ACCESS and DONE, plus ERR when DM_TIMEOUT_EN is defined.
REQ-004 IDLE: access = mem_DM_read|mem_DM_write; if access, go to ACCESS and register dm_req=1, dm_addr=mem_alu_result, dm_wdata=mem_sw_o and dm_we=mem_DM_write.
REQ-005 When read and write are both set, the controller SHALL perform a store (dm_we=1).
REQ-006 ACCESS: dm_req, dm_we, dm_addr and dm_wdata SHALL hold stable until the cycle after dm_ack.
REQ-007 ACCESS with dm_ack=1: the next state SHALL be DONE, dm_req SHALL be 0 at the next edge, and mem_lw_data SHALL capture dm_rdata on a load.
REQ-008 A store SHALL leave mem_lw_data unchanged.
REQ-009 DONE SHALL always go to IDLE after one cycle and SHALL NOT start a new access, because the same instruction is still in MEM during that cycle.
REQ-010 pipe_stall SHALL be combinational: 1 when (state==IDLE and access) or state==ACCESS or state==ERR, else 0.
REQ-011 Minimum latency (ack in the first ACCESS cycle): pipe_stall high 2 cycles, low in DONE, pipeline advances at the end of DONE.
REQ-012 dm_ack SHALL be ignored in IDLE and DONE.
REQ-013 A back-to-back memory instruction entering MEM at the end of DONE SHALL start a new access from IDLE on the next cycle.

Reset
REQ-014 When rst=1 at a clock edge: state=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, mem_lw_data=0, dm_err=0, timeout counter=0.
REQ-015 rst asserted mid-access SHALL abandon the access; dm_req SHALL be 0 after that edge and a late dm_ack SHALL be ignored.
REQ-016 pipe_stall SHALL be 0 while in reset.

Configuration
REQ-017 With macro DM_TIMEOUT_EN defined: the counter clears on IDLE->ACCESS and increments each ACCESS cycle without ack.
REQ-018 With DM_TIMEOUT_EN defined: when the count reaches TIMEOUT_CYC, go to ERR (dm_req=0, mem_lw_data=0, dm_err=1 for one cycle), then to DONE.
REQ-019 With DM_TIMEOUT_EN defined: dm_ack on the same cycle as the limit SHALL win, giving a normal completion.
REQ-020 Without DM_TIMEOUT_EN: ACCESS waits indefinitely, dm_err SHALL be tied to 0, and no counter or ERR state exists.

Structure
REQ-021 Bus widths SHALL come from the shared RegBus defines.
REQ-022 The state enum dm_state_t and the TIMEOUT_CYC default SHALL live in the shared package pipe_ctrl_pkg.
REQ-023 The timeout counter SHALL be the sub-module dm_timeout_cnt (clk, rst, clr, en, hit), instantiated only under DM_TIMEOUT_EN.

Verification
REQ-024 Load at addr 0x0000_0040, dm_ack in the 1st ACCESS cycle with rdata 0xDEAD_BEEF -> pipe_stall high 2 cycles, mem_lw_data=0xDEAD_BEEF in DONE, dm_req low after ack.
REQ-025 Store 0x1234_5678 to 0x0000_0080 with ack after 3 wait cycles -> dm_we=1, addr and data stable 4 cycles, mem_lw_data unchanged.
REQ-026 Back-to-back load then store -> exactly one DONE cycle between them and two distinct dm_req assertions.
REQ-027 Spurious dm_ack in IDLE -> no state change and mem_lw_data unchanged.
REQ-028 rst pulsed during ACCESS followed by a late dm_ack -> IDLE, dm_req=0, all outputs at reset values.
REQ-029 DM_TIMEOUT_EN defined, TIMEOUT_CYC=4, no ack -> ERR after 4 ACCESS cycles, dm_err one-cycle pulse, mem_lw_data=0, stall released in DONE.
